// File: rtl/alu.sv
// alu: 16-bit registered ALU with zero/negative/carry/overflow flags, one-cycle latency.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Zero,
  output logic             Neg,
  output logic             Carry,
  output logic             Ovf
);
  logic [WIDTH-1:0] res_d, res_q;
  logic             carry_d, carry_q, ovf_d, ovf_q, zero_q, neg_q;
  logic [WIDTH:0]   sum, dif, shl, shr;
  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = {1'b0, A} - {1'b0, B};
  // Extra bit on the far side of each shift catches the last bit shifted out; zero amount leaves it 0.
  assign shl = {1'b0, A} << B[3:0];
  assign shr = {A, 1'b0} >> B[3:0];
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (ALU_Sel)
      3'd0: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'd1: begin
        res_d   = dif[WIDTH-1:0];
        carry_d = dif[WIDTH];
        ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      3'd2: res_d = A & B;
      3'd3: res_d = A | B;
      3'd4: res_d = A ^ B;
      3'd5: res_d = ~A;
      3'd6: begin
        res_d   = shl[WIDTH-1:0];
        carry_d = shl[WIDTH];
      end
      default: begin
        res_d   = shr[WIDTH:1];
        carry_d = shr[0];
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= res_d == '0;
      neg_q   <= res_d[WIDTH-1];
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
  assign ALU_Out = res_q;
  assign Zero    = zero_q;
  assign Neg     = neg_q;
  assign Carry   = carry_q;
  assign Ovf     = ovf_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed scoreboard bench for alu; expected {out,Z,N,C,V} come from a behavioural model.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [2:0]  sel = '0;
  logic [15:0] alu_out;
  logic        zero, neg, carry, ovf;
  logic [19:0] sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  alu dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .ALU_Sel(sel),
    .ALU_Out(alu_out), .Zero(zero), .Neg(neg), .Carry(carry), .Ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [2:0] op, input logic r);
    logic [15:0] res;
    logic        c, v;
    int          s;
    res = '0; c = 1'b0; v = 1'b0;
    if (r) return {16'h0000, 4'b1000};
    s = 0;
    case (op)
      3'd0: begin
        s = int'(x) + int'(y);
        res = s[15:0];
        c = s > 65535;
        v = (x[15] == y[15]) && (res[15] != x[15]);
      end
      3'd1: begin
        s = int'(x) - int'(y);
        res = s[15:0];
        c = int'(x) < int'(y);
        v = (x[15] != y[15]) && (res[15] != x[15]);
      end
      3'd2: res = x & y;
      3'd3: res = x | y;
      3'd4: res = x ^ y;
      3'd5: res = ~x;
      3'd6: begin
        res = x;
        for (int i = 0; i < int'(y[3:0]); i++) begin
          c = res[15];
          res = {res[14:0], 1'b0};
        end
      end
      default: begin
        res = x;
        for (int i = 0; i < int'(y[3:0]); i++) begin
          c = res[0];
          res = {1'b0, res[15:1]};
        end
      end
    endcase
    return {res, res == 16'h0000, res[15], c, v};
  endfunction
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [2:0] op, input logic r);
    logic [19:0] exp, got;
    @(negedge clk);
    a = x; b = y; sel = op; rst = r;
    sb.push_back(model(x, y, op, r));
    @(posedge clk);
    #1;
    got = {alu_out, zero, neg, carry, ovf};
    exp = sb.pop_front();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    step("reset", 16'h1234, 16'h5678, 3'd0, 1'b1);
    step("reset_hold_a", 16'hFFFF, 16'h0001, 3'd0, 1'b1);
    step("reset_hold_b", 16'h8000, 16'h0001, 3'd5, 1'b1);
    for (int i = 0; i < 8; i++)
      step($sformatf("sweep_op%0d", i), 16'h0AB0, 16'h01AC, 3'(i), 1'b0);
    step("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 1'b0);
    step("add_ovf", 16'h7FFF, 16'h0001, 3'd0, 1'b0);
    step("add_neg_ovf", 16'h8000, 16'h8000, 3'd0, 1'b0);
    step("sub_borrow", 16'h0001, 16'h0002, 3'd1, 1'b0);
    step("sub_ovf", 16'h8000, 16'h0001, 3'd1, 1'b0);
    step("sub_zero", 16'h5555, 16'h5555, 3'd1, 1'b0);
    step("sll_1", 16'h8001, 16'h0001, 3'd6, 1'b0);
    step("srl_15", 16'h8001, 16'h000F, 3'd7, 1'b0);
    step("sll_0", 16'hA5A5, 16'hFFF0, 3'd6, 1'b0);
    step("srl_0", 16'h8001, 16'h0000, 3'd7, 1'b0);
    step("srl_1", 16'h0003, 16'h0001, 3'd7, 1'b0);
    step("sll_15", 16'h0003, 16'h000F, 3'd6, 1'b0);
    step("not_b_ignored", 16'h0000, 16'h1234, 3'd5, 1'b0);
    step("mid_add", 16'h1111, 16'h2222, 3'd0, 1'b0);
    step("mid_rst", 16'h1111, 16'h2222, 3'd0, 1'b1);
    step("post_rst_add", 16'h0F0F, 16'h0101, 3'd0, 1'b0);
    step("hold_add", 16'h0F0F, 16'h0101, 3'd0, 1'b0);
    for (int i = 0; i < 24; i++)
      step("random", 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
